register_file_mp: RTL and testbench
===================================

# register_file_mp

Parametrised multi-port successor to the core's integer register file. It provides NUM_READ registered read ports and one write port, with:
- optional write-to-read bypass;
- a hardwired zero register;
- a reset sequencer that clears the block-RAM array one entry per cycle and loads the stack pointer.

It sits between decode (read addresses) and writeback (write port). Decode must not issue until `ready` is high.

## Interface
- DATAW, 32, register width in bits
- NUM_REGS, 32, number of architectural registers (power of two)
- ADDRW, $clog2(NUM_REGS), register address width
- NUM_READ, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write forwarded to matching read (write-first); 0 = read returns old value (read-first)
- ZERO_REG, 1, 1 = index 0 reads as zero and ignores writes
- SP_INDEX, 2, register loaded with SP_INIT at reset
- SP_INIT, 32'h01000000 + `MEM_DEPTH, stack-pointer reset value

- clock  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- ready  out  1  high once initialisation sweep completes
- write_enable  in  1  write data_rd to addr_rd this cycle
- addr_rd  in  ADDRW  write address
- data_rd  in  DATAW  write data
- read_hold  in  1  1 = all read outputs keep their current value (pipeline stall)
- addr_rs  in  NUM_READ*ADDRW  read addresses, port k at bits [k*ADDRW +: ADDRW]
- data_rs  out  NUM_READ*DATAW  read data, port k at bits [k*DATAW +: DATAW]

## Operation
- FSM states: INIT, RUN.
- reset_n low at a clock edge: state becomes INIT, sweep counter 0, ready 0, data_rs all 0.
- INIT:
  - each cycle writes 0 to regs[counter], or SP_INIT when counter == SP_INDEX; counter increments.
  - after writing NUM_REGS-1, state becomes RUN and ready rises.
  - external write_enable is ignored; data_rs stays 0 regardless of read_hold.
- RUN:
  - write_enable=1 writes regs[addr_rd] <= data_rd, except when ZERO_REG=1 and addr_rd==0 (dropped).
  - each read port k with read_hold=0 registers regs[addr_rs_k].
  - read override priority:
    - ZERO_REG=1 and addr_rs_k==0: value is 0.
    - else BYPASS=1, write_enable=1 and addr_rd==addr_rs_k: value is data_rd.
  - BYPASS=0 with a matching address returns the pre-write value; the new value is visible next cycle.
  - multiple ports with the same address all return the same value.
- Reset asserted mid-INIT or mid-RUN restarts the sweep from counter 0. Prior contents are discarded.
- Array is block-RAM style: no per-entry reset. Clearing happens only through the sweep.

## Timing
- ready rises exactly NUM_REGS cycles after the first clock with reset_n high (32 for defaults).
- Read latency: 1 cycle; address at edge N, data valid after edge N+1.
- Write visible to a non-bypassed read issued at edge N+1 or later.
- read_hold=1 at edge N: data_rs after edge N equals data_rs before edge N. A write at the same edge still commits to the array.
- Reset values: ready 0, data_rs 0, state INIT, counter 0.

## Structure
- Package regfile_pkg:
  - state enum (INIT, RUN);
  - default SP_INIT constant;
  - MAX_READ_PORTS = 4.
- Sub-module regfile_init_seq: owns the FSM and sweep counter. Outputs init_we, init_addr, init_data and ready. The top muxes these onto the array write port while in INIT.
- Read ports are generated by a for-generate over NUM_READ. Each has its own bypass and zero compare.
- Array is replicated per read port if the target BRAM has fewer ports. Behaviour must match a single array.

## Test plan
- Reset release, defaults: ready goes 1 on exactly the 32nd cycle. Reads of x2 return 32'h01000000+`MEM_DEPTH. Reads of x5 return 0.
- Write x5=32'hDEADBEEF, then read x5 on port 0 and port 1 next cycle -> both return 32'hDEADBEEF.
- BYPASS=1: write x7=32'h12345678 while reading x7 the same cycle -> 32'h12345678. BYPASS=0 build -> old value 0, then 32'h12345678 one cycle later.
- ZERO_REG=1: write x0=32'hFFFFFFFF with a simultaneous x0 read -> 0 now and on later reads.
- read_hold=1 for 3 cycles while addr_rs changes and x3 is written -> data_rs unchanged. After release, the new x3 value is seen.
- reset_n low for 1 cycle mid-RUN after writing x9=32'hA5A5A5A5 -> ready 0 and data_rs 0. A write during the sweep is ignored. After 32 cycles, x9 reads 0 and x2 reads SP_INIT.

Source files
------------

// File: rtl/register_file_mp_pkg.sv
// Shared types and constants for the multi-port integer register file.
// The stack-pointer reset value is derived from the platform memory depth.
`ifndef MEM_DEPTH
`define MEM_DEPTH 32'h0000_4000
`endif

package regfile_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } rf_state_e;

  localparam int MAX_READ_PORTS = 4;

  localparam logic [31:0] SP_INIT_DEFAULT = 32'h0100_0000 + `MEM_DEPTH;

endpackage

// File: rtl/register_file_mp_init_seq.sv
// Reset sequencer: sweeps every array entry once after reset, loading zero
// everywhere except the stack-pointer entry, then raises ready.
module regfile_init_seq
  import regfile_pkg::*;
#(
  parameter int              DATAW    = 32,
  parameter int              NUM_REGS = 32,
  parameter int              ADDRW    = $clog2(NUM_REGS),
  parameter int              SP_INDEX = 2,
  parameter logic [DATAW-1:0] SP_INIT = SP_INIT_DEFAULT
) (
  input  logic             clock,
  input  logic             reset_n,
  output logic             ready,
  output logic             init_we,
  output logic [ADDRW-1:0] init_addr,
  output logic [DATAW-1:0] init_data
);

  localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(NUM_REGS - 1);
  localparam logic [ADDRW-1:0] SP_ADDR   = ADDRW'(SP_INDEX);

  rf_state_e        state_r;
  rf_state_e        state_nxt_s;
  logic [ADDRW-1:0] count_r;
  logic [ADDRW-1:0] count_nxt_s;
  logic             ready_r;

  // State, sweep counter and ready flag
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r <= ST_INIT;
      count_r <= '0;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
      ready_r <= (state_nxt_s == ST_RUN);
    end
  end

  // Next state: advance the sweep, leave INIT after the last entry
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    case (state_r)
      ST_INIT: begin
        if (count_r == LAST_ADDR) begin
          state_nxt_s = ST_RUN;
          count_nxt_s = '0;
        end else begin
          state_nxt_s = ST_INIT;
          count_nxt_s = count_r + ADDRW'(1);
        end
      end
      ST_RUN: begin
        state_nxt_s = ST_RUN;
        count_nxt_s = count_r;
      end
      default: begin
        state_nxt_s = ST_INIT;
        count_nxt_s = '0;
      end
    endcase
  end

  // Sweep write port, decoded straight from the registered state
  always_comb begin
    init_we   = (state_r == ST_INIT);
    init_addr = count_r;
    if (count_r == SP_ADDR) begin
      init_data = SP_INIT;
    end else begin
      init_data = '0;
    end
  end

  assign ready = ready_r;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: NUM_READ registered read ports, one write port,
// optional write-to-read bypass, hardwired zero register and a clearing sweep.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int               DATAW    = 32,
  parameter int               NUM_REGS = 32,
  parameter int               ADDRW    = $clog2(NUM_REGS),
  parameter int               NUM_READ = 2,
  parameter bit               BYPASS   = 1'b1,
  parameter bit               ZERO_REG = 1'b1,
  parameter int               SP_INDEX = 2,
  parameter logic [DATAW-1:0] SP_INIT  = SP_INIT_DEFAULT
) (
  input  logic                      clock,
  input  logic                      reset_n,
  output logic                      ready,
  input  logic                      write_enable,
  input  logic [ADDRW-1:0]          addr_rd,
  input  logic [DATAW-1:0]          data_rd,
  input  logic                      read_hold,
  input  logic [NUM_READ*ADDRW-1:0] addr_rs,
  output logic [NUM_READ*DATAW-1:0] data_rs
);

  if (NUM_READ < 32'sd1 || NUM_READ > MAX_READ_PORTS) begin : g_bad_num_read
    $error("register_file_mp: NUM_READ out of supported range");
  end

  logic             ready_s;
  logic             init_we_s;
  logic [ADDRW-1:0] init_addr_s;
  logic [DATAW-1:0] init_data_s;
  logic             wr_en_s;
  logic [ADDRW-1:0] wr_addr_s;
  logic [DATAW-1:0] wr_data_s;
  logic             zero_drop_s;

  regfile_init_seq #(
    .DATAW    (DATAW),
    .NUM_REGS (NUM_REGS),
    .ADDRW    (ADDRW),
    .SP_INDEX (SP_INDEX),
    .SP_INIT  (SP_INIT)
  ) u_init_seq (
    .clock     (clock),
    .reset_n   (reset_n),
    .ready     (ready_s),
    .init_we   (init_we_s),
    .init_addr (init_addr_s),
    .init_data (init_data_s)
  );

  assign ready = ready_s;

  // Array write port: the sweep owns it during INIT, writeback afterwards
  always_comb begin
    zero_drop_s = ZERO_REG && (addr_rd == '0);
    if (init_we_s) begin
      wr_en_s   = 1'b1;
      wr_addr_s = init_addr_s;
      wr_data_s = init_data_s;
    end else begin
      wr_en_s   = write_enable && !zero_drop_s;
      wr_addr_s = addr_rd;
      wr_data_s = data_rd;
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_port
    logic [DATAW-1:0] bank_r [NUM_REGS];
    logic [ADDRW-1:0] raddr_s;
    logic [DATAW-1:0] rvalue_s;
    logic [DATAW-1:0] rdata_r;

    assign raddr_s = addr_rs[k*ADDRW +: ADDRW];

    // Private array copy; every copy receives the identical write stream
    always_ff @(posedge clock) begin
      if (reset_n && wr_en_s) begin
        bank_r[wr_addr_s] <= wr_data_s;
      end
    end

    // Read value with zero-register and write-first overrides
    always_comb begin
      rvalue_s = bank_r[raddr_s];
      if (ZERO_REG && (raddr_s == '0)) begin
        rvalue_s = '0;
      end else if (BYPASS && write_enable && (addr_rd == raddr_s)) begin
        rvalue_s = data_rd;
      end else begin
        rvalue_s = bank_r[raddr_s];
      end
    end

    // Output register: forced to zero until the sweep is done, frozen on hold
    always_ff @(posedge clock) begin
      if (!reset_n) begin
        rdata_r <= '0;
      end else if (!ready_s) begin
        rdata_r <= '0;
      end else if (!read_hold) begin
        rdata_r <= rvalue_s;
      end else begin
        rdata_r <= rdata_r;
      end
    end

    assign data_rs[k*DATAW +: DATAW] = rdata_r;
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: a write-first (default) instance and a
// read-first instance share all inputs and are checked against a vector table.
module tb_register_file_mp;
  import regfile_pkg::*;

  localparam logic [31:0] SP = SP_INIT_DEFAULT;

  logic        clock;
  logic        reset_n;
  logic        write_enable;
  logic [4:0]  addr_rd;
  logic [31:0] data_rd;
  logic        read_hold;
  logic [9:0]  addr_rs;
  logic        ready_a;
  logic        ready_b;
  logic [63:0] rs_a;
  logic [63:0] rs_b;

  int checks;
  int failures;

  register_file_mp dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .ready        (ready_a),
    .write_enable (write_enable),
    .addr_rd      (addr_rd),
    .data_rd      (data_rd),
    .read_hold    (read_hold),
    .addr_rs      (addr_rs),
    .data_rs      (rs_a)
  );

  register_file_mp #(.BYPASS(1'b0)) dut_rf (
    .clock        (clock),
    .reset_n      (reset_n),
    .ready        (ready_b),
    .write_enable (write_enable),
    .addr_rd      (addr_rd),
    .data_rd      (data_rd),
    .read_hold    (read_hold),
    .addr_rs      (addr_rs),
    .data_rs      (rs_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        hold;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;   // write-first instance, port 0
    logic [31:0] e1;
    logic [31:0] n0;   // read-first instance, port 0
    logic [31:0] n1;
  } vec_t;

  vec_t vecs [16];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int cycles;
    cycles = 0;
    while (!(ready_a && ready_b) && cycles < 40) begin
      tick();
      cycles++;
      if (!(ready_a && ready_b)) begin
        check({name, "_rs_a_init"}, rs_a[31:0] | rs_a[63:32], 32'h0);
      end
    end
    check({name, "_ready_cycles"}, cycles, 32'd32);
    check({name, "_ready_b"}, {31'h0, ready_b}, 32'd1);
    check({name, "_rs_a_at_ready"}, rs_a[31:0] | rs_a[63:32], 32'h0);
    check({name, "_rs_b_at_ready"}, rs_b[31:0] | rs_b[63:32], 32'h0);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    reset_n      = 1'b0;
    write_enable = 1'b0;
    addr_rd      = 5'd0;
    data_rd      = 32'h0;
    read_hold    = 1'b0;
    addr_rs      = {5'd5, 5'd2};

    //             we    waddr   wdata          hold  ra0    ra1    e0             e1             n0             n1
    vecs[0]  = '{1'b0, 5'd0,  32'h0000_0000, 1'b0, 5'd2,  5'd5,  SP,            32'h0,         SP,            32'h0};
    vecs[1]  = '{1'b1, 5'd5,  32'hDEAD_BEEF, 1'b0, 5'd5,  5'd5,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0,         32'h0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0000_0000, 1'b0, 5'd5,  5'd5,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b1, 5'd7,  32'h1234_5678, 1'b0, 5'd7,  5'd2,  32'h1234_5678, SP,            32'h0,         SP};
    vecs[4]  = '{1'b0, 5'd0,  32'h0000_0000, 1'b0, 5'd7,  5'd7,  32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678};
    vecs[5]  = '{1'b1, 5'd0,  32'hFFFF_FFFF, 1'b0, 5'd0,  5'd5,  32'h0,         32'hDEAD_BEEF, 32'h0,         32'hDEAD_BEEF};
    vecs[6]  = '{1'b0, 5'd0,  32'h0000_0000, 1'b0, 5'd0,  5'd0,  32'h0,         32'h0,         32'h0,         32'h0};
    vecs[7]  = '{1'b0, 5'd0,  32'h0000_0000, 1'b0, 5'd3,  5'd7,  32'h0,         32'h1234_5678, 32'h0,         32'h1234_5678};
    vecs[8]  = '{1'b1, 5'd3,  32'hCAFE_F00D, 1'b1, 5'd2,  5'd5,  32'h0,         32'h1234_5678, 32'h0,         32'h1234_5678};
    vecs[9]  = '{1'b0, 5'd0,  32'h0000_0000, 1'b1, 5'd3,  5'd3,  32'h0,         32'h1234_5678, 32'h0,         32'h1234_5678};
    vecs[10] = '{1'b0, 5'd0,  32'h0000_0000, 1'b1, 5'd9,  5'd0,  32'h0,         32'h1234_5678, 32'h0,         32'h1234_5678};
    vecs[11] = '{1'b0, 5'd0,  32'h0000_0000, 1'b0, 5'd3,  5'd3,  32'hCAFE_F00D, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'hCAFE_F00D};
    vecs[12] = '{1'b1, 5'd31, 32'h1357_9BDF, 1'b0, 5'd31, 5'd30, 32'h1357_9BDF, 32'h0,         32'h0,         32'h0};
    vecs[13] = '{1'b0, 5'd0,  32'h0000_0000, 1'b0, 5'd31, 5'd1,  32'h1357_9BDF, 32'h0,         32'h1357_9BDF, 32'h0};
    vecs[14] = '{1'b1, 5'd9,  32'hA5A5_A5A5, 1'b0, 5'd9,  5'd2,  32'hA5A5_A5A5, SP,            32'h0,         SP};
    vecs[15] = '{1'b0, 5'd0,  32'h0000_0000, 1'b0, 5'd9,  5'd9,  32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5};

    tick();
    tick();
    check("reset_ready", {31'h0, ready_a}, 32'd0);
    check("reset_rs_a0", rs_a[31:0], 32'h0);
    check("reset_rs_a1", rs_a[63:32], 32'h0);

    // Initial sweep; writes issued during INIT must be ignored
    reset_n      = 1'b1;
    write_enable = 1'b1;
    addr_rd      = 5'd5;
    data_rd      = 32'h7777_7777;
    wait_ready("init");
    write_enable = 1'b0;

    for (int i = 0; i < 16; i++) begin
      write_enable = vecs[i].we;
      addr_rd      = vecs[i].waddr;
      data_rd      = vecs[i].wdata;
      read_hold    = vecs[i].hold;
      addr_rs      = {vecs[i].ra1, vecs[i].ra0};
      tick();
      check($sformatf("vec%0d_a0", i), rs_a[31:0],  vecs[i].e0);
      check($sformatf("vec%0d_a1", i), rs_a[63:32], vecs[i].e1);
      check($sformatf("vec%0d_b0", i), rs_b[31:0],  vecs[i].n0);
      check($sformatf("vec%0d_b1", i), rs_b[63:32], vecs[i].n1);
    end

    // One-cycle reset mid-RUN, then a write held high through the sweep
    write_enable = 1'b0;
    read_hold    = 1'b0;
    reset_n      = 1'b0;
    tick();
    check("midrun_ready", {31'h0, ready_a}, 32'd0);
    check("midrun_rs_a", rs_a[31:0] | rs_a[63:32], 32'h0);
    check("midrun_rs_b", rs_b[31:0] | rs_b[63:32], 32'h0);

    reset_n      = 1'b1;
    write_enable = 1'b1;
    addr_rd      = 5'd9;
    data_rd      = 32'h1111_1111;
    addr_rs      = {5'd2, 5'd9};
    wait_ready("resweep");
    write_enable = 1'b0;
    tick();
    check("resweep_x9_a", rs_a[31:0],  32'h0);
    check("resweep_x2_a", rs_a[63:32], SP);
    check("resweep_x9_b", rs_b[31:0],  32'h0);
    check("resweep_x2_b", rs_b[63:32], SP);

    addr_rs = {5'd5, 5'd7};
    tick();
    check("resweep_x7_a", rs_a[31:0],  32'h0);
    check("resweep_x5_a", rs_a[63:32], 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
